switch_move_encoder: RTL and testbench

//  Front end for the frog movement path: turns the four raw board switches into single move commands.
//  - Synchronises each switch and debounces it.
//  - Detects presses and resolves simultaneous presses by priority.
//  - Presents one command at a time on a valid/ready handshake to the frog movement controller.
//  - Optional auto-repeat emits further commands while a switch is held.

---
 rtl/frogger_pkg.sv | 28 ++
 rtl/switch_debouncer.sv | 50 +++++
 rtl/switch_move_encoder.sv | 141 ++++++++++++++
 tb/tb_switch_move_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared constants for the frog movement path: move directions used by the
// switch encoder, the frog controller and the vga_controller, plus the
// command register state encoding and the direction priority helper.
package frogger_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_t;

  // Highest-priority set bit wins: bit0 (up) > bit1 (down) > bit2 (left) > bit3 (right).
  // With no bit set the result is DIR_UP; callers qualify it with |req.
  function automatic logic [1:0] prio_dir(input logic [3:0] req);
    logic [1:0] dir;
    dir = DIR_UP;
    if (req[3]) dir = DIR_RIGHT;
    if (req[2]) dir = DIR_LEFT;
    if (req[1]) dir = DIR_DOWN;
    if (req[0]) dir = DIR_UP;
    return dir;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One board switch: two-flop synchroniser, stable-level debounce counter,
// debounced level and a one-cycle rising-edge pulse of that level.
// The synchroniser flops carry no reset so that a switch held through reset
// is already visible downstream and re-debounces immediately.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic pressed,
  output logic rise
);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             pressed_q;

  // Two-flop synchroniser for the asynchronous switch input
  always_ff @(posedge clk) begin
    sync_p0 <= sw_raw;
    sync_p1 <= sync_p0;
  end

  // Debounce: count cycles the synchronised level differs, toggle once it has held long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (sync_p1 == pressed) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt     <= '0;
      pressed <= ~pressed;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection
  always_ff @(posedge clk) begin
    if (reset) pressed_q <= 1'b0;
    else       pressed_q <= pressed;
  end

  assign rise = pressed & ~pressed_q;

endmodule

// File: rtl/switch_move_encoder.sv
// Turns the four raw board switches into single move commands for the frog
// movement controller on a valid/ready handshake. Simultaneous presses are
// resolved up > down > left > right; one command is held at a time and any
// event arriving while a command is pending is dropped.
// Optional feature: define SWITCH_MOVE_AUTO_REPEAT_EN to emit repeat commands
// while the highest-priority pressed switch stays held.
module switch_move_encoder
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 7500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CNT_W           = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic [3:0] pressed
);

  logic [3:0] sw_raw;
  logic [3:0] rise;
  logic       evt_vld;
  logic [1:0] evt_dir;
  logic       take;
  logic [1:0] dir_q;
  cmd_state_t state_q;
  cmd_state_t state_d;

  assign sw_raw = {switch4, switch3, switch2, switch1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .sw_raw  (sw_raw[i]),
      .pressed (pressed[i]),
      .rise    (rise[i])
    );
  end

`ifdef SWITCH_MOVE_AUTO_REPEAT_EN
  logic             rep_act;
  logic             rep_first;
  logic [1:0]       rep_dir;
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_held;
  logic             rep_fire;
  logic [1:0]       hp_dir;

  assign hp_dir   = prio_dir(pressed);
  // Repeat only counts for the switch that is still the top-priority one held.
  assign rep_held = (|pressed) && (hp_dir == rep_dir);
  assign rep_fire = rep_act && rep_held &&
                    (rep_first ? (rep_cnt == CNT_W'(REPEAT_PERIOD))
                               : (rep_cnt == CNT_W'(REPEAT_DELAY)));

  // Repeat timer: armed by a rise of the top-priority switch, cleared when that switch stops being it
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_dir   <= DIR_UP;
      rep_cnt   <= '0;
    end else if ((|rise) && (prio_dir(rise) == hp_dir)) begin
      rep_act   <= 1'b1;
      rep_first <= 1'b0;
      rep_dir   <= hp_dir;
      rep_cnt   <= CNT_W'(1);
    end else if (rep_act && !rep_held) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b1;
      rep_cnt   <= CNT_W'(1);
    end else if (rep_act) begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end

  // Event source: a fresh press wins over a repeat in the same cycle
  always_comb begin
    evt_vld = |rise;
    evt_dir = prio_dir(rise);
    if (!(|rise) && rep_fire) begin
      evt_vld = 1'b1;
      evt_dir = rep_dir;
    end
  end
`else
  logic [CNT_W-1:0] unused_rep_cfg;
  assign unused_rep_cfg = CNT_W'(REPEAT_DELAY) ^ CNT_W'(REPEAT_PERIOD);

  // Event source: debounced presses only, highest priority kept
  always_comb begin
    evt_vld = |rise;
    evt_dir = prio_dir(rise);
  end
`endif

  // Command state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= CMD_IDLE;
    else       state_q <= state_d;
  end

  // Next state: accept an event only when idle, release on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD_IDLE: if (evt_vld)    state_d = CMD_PEND;
      CMD_PEND: if (move_ready) state_d = CMD_IDLE;
      default:                  state_d = CMD_IDLE;
    endcase
  end

  // Outputs: valid while pending, load strobe for the direction register
  always_comb begin
    move_valid = (state_q == CMD_PEND);
    take       = (state_q == CMD_IDLE) && evt_vld;
  end

  // Direction register: loaded on acceptance, stable while pending
  always_ff @(posedge clk) begin
    if (reset)     dir_q <= DIR_UP;
    else if (take) dir_q <= evt_dir;
  end

  assign move_dir = dir_q;

endmodule

// File: tb/tb_switch_move_encoder.sv
// Self-checking bench for switch_move_encoder with short debounce/repeat
// timings. A cycle table covers reset, a single press and release, and a
// short glitch; hand-written sequences cover priority, backpressure, reset
// while held, and (with SWITCH_MOVE_AUTO_REPEAT_EN) auto-repeat.
module tb_switch_move_encoder;
  import frogger_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] pressed;

  int n_cmp = 0;
  int n_err = 0;

  int first_v;
  int n_hs;
  int n_tgt;
  int tgt_t;
  int hs_t [8];

  typedef struct {
    logic [3:0] sw;
    logic       rdy;
    logic       rst;
    logic       exp_v;
    logic [1:0] exp_d;
    logic [3:0] exp_p;
  } vec_t;

  vec_t tbl [31];

  always #5 clk = ~clk;

  switch_move_encoder #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switch1    (sw[0]),
    .switch2    (sw[1]),
    .switch3    (sw[2]),
    .switch4    (sw[3]),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .pressed    (pressed)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Observe n cycles at the falling edge; record first valid, handshakes, and handshakes of dir tgt.
  task automatic watch(input int n, input logic [1:0] tgt);
    first_v = 0;
    n_hs    = 0;
    n_tgt   = 0;
    tgt_t   = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (move_valid && first_v == 0) first_v = j;
      if (move_valid && move_ready) begin
        if (n_hs < 8) hs_t[n_hs] = j;
        n_hs++;
        if (move_dir == tgt) begin
          n_tgt++;
          if (tgt_t == 0) tgt_t = j;
        end
      end
    end
  endtask

  initial begin
    int exp_t [6];
    exp_t = '{7, 27, 35, 43, 51, 59};

    // reset, switch3 press/hold/release, switch1 3-cycle glitch
    for (int i = 0; i <= 2; i++)   tbl[i] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000};
    for (int i = 3; i <= 7; i++)   tbl[i] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000};
    tbl[8] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100};
    tbl[9] = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0100};
    for (int i = 10; i <= 12; i++) tbl[i] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0100};
    for (int i = 13; i <= 17; i++) tbl[i] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0100};
    for (int i = 18; i <= 19; i++) tbl[i] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000};
    for (int i = 20; i <= 22; i++) tbl[i] = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000};
    for (int i = 23; i <= 30; i++) tbl[i] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000};

    for (int i = 0; i < 31; i++) begin
      sw         = tbl[i].sw;
      move_ready = tbl[i].rdy;
      reset      = tbl[i].rst;
      @(negedge clk);
      chk($sformatf("row%0d_valid", i),   int'(move_valid), int'(tbl[i].exp_v));
      chk($sformatf("row%0d_dir", i),     int'(move_dir),   int'(tbl[i].exp_d));
      chk($sformatf("row%0d_pressed", i), int'(pressed),    int'(tbl[i].exp_p));
    end

    // switch2 and switch4 together: down wins, switch4 dropped until re-pressed
    sw = 4'b1010;
    watch(14, DIR_DOWN);
    chk("t3_cmds", n_hs, 1);
    chk("t3_down_cmds", n_tgt, 1);
    chk("t3_latency", tgt_t, 7);
    sw = 4'b0010;
    watch(12, DIR_RIGHT);
    chk("t3_release_right_cmds", n_tgt, 0);
`ifndef SWITCH_MOVE_AUTO_REPEAT_EN
    chk("t3_release_cmds", n_hs, 0);
`endif
    chk("t3_pressed_after_release", int'(pressed), 4'b0010);
    sw = 4'b1010;
    watch(12, DIR_RIGHT);
    chk("t3_repress_right_cmds", n_tgt, 1);
    chk("t3_repress_latency", tgt_t, 7);
    chk("t3_pressed_both", int'(pressed), 4'b1010);
    sw = 4'b0000;
    watch(12, DIR_UP);
    chk("t3_pressed_clear", int'(pressed), 0);
    chk("t3_idle", int'(move_valid), 0);

    // backpressure: right held pending, up press lost
    move_ready = 1'b0;
    sw = 4'b1000;
    watch(10, DIR_RIGHT);
    chk("t4_first_valid", first_v, 7);
    chk("t4_valid_held", int'(move_valid), 1);
    chk("t4_dir_right", int'(move_dir), int'(DIR_RIGHT));
    chk("t4_pressed_right", int'(pressed), 4'b1000);
    sw = 4'b1001;
    watch(10, DIR_UP);
    chk("t4_still_valid", int'(move_valid), 1);
    chk("t4_dir_stable", int'(move_dir), int'(DIR_RIGHT));
    chk("t4_pressed_both", int'(pressed), 4'b1001);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    chk("t4_valid_dropped", int'(move_valid), 0);
    watch(10, DIR_UP);
    chk("t4_up_lost", first_v, 0);
    sw = 4'b0000;
    move_ready = 1'b1;
    watch(14, DIR_UP);
    chk("t4_drained", int'(move_valid), 0);
    chk("t4_pressed_clear", int'(pressed), 0);

    // reset while up is held and pending
    move_ready = 1'b0;
    sw = 4'b0001;
    watch(10, DIR_UP);
    chk("t5_first_valid", first_v, 7);
    chk("t5_dir_up", int'(move_dir), int'(DIR_UP));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_reset_valid", int'(move_valid), 0);
    chk("t5_reset_dir", int'(move_dir), 0);
    chk("t5_reset_pressed", int'(pressed), 0);
    watch(8, DIR_UP);
    chk("t5_reissue_latency", first_v, 5);
    chk("t5_reissue_valid", int'(move_valid), 1);
    chk("t5_reissue_dir", int'(move_dir), int'(DIR_UP));
    chk("t5_reissue_pressed", int'(pressed), 4'b0001);
    sw = 4'b0000;
    move_ready = 1'b1;
    watch(12, DIR_UP);
    chk("t5_drained", int'(move_valid), 0);

    // switch1 held 60 cycles with the consumer always ready
    sw = 4'b0001;
    watch(60, DIR_UP);
`ifdef SWITCH_MOVE_AUTO_REPEAT_EN
    chk("t6_cmds", n_hs, 6);
    chk("t6_up_cmds", n_tgt, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t6_cmd%0d_time", k), hs_t[k], exp_t[k]);
`else
    chk("t6_cmds", n_hs, 1);
    chk("t6_cmd0_time", hs_t[0], exp_t[0]);
`endif
    sw = 4'b0000;
    watch(12, DIR_UP);
    chk("t6_after_release_cmds", n_hs, 0);
    chk("t6_pressed_clear", int'(pressed), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
